// File: rtl/debounce_pulse_if.sv
// Signal bundle between a raw button source and the debounce_pulse conditioner.
// The source drives btn_in; the conditioner returns the clean level, edge strobes and busy.
interface debounce_pulse_if;
  logic btn_in;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/debounce_pulse.sv
// Button/switch conditioner: 2-flop synchronizer, stability-count FSM and registered
// level plus single-cycle rise/fall strobes.
module debounce_pulse #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic            clk,
  input  logic            reset,
  debounce_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  state_t           state_p2;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_p2;
  logic [CNT_W-1:0] cnt_nx;
  logic             level_p2;
  logic             level_nx;
  logic             rise_p2;
  logic             rise_nx;
  logic             fall_p2;
  logic             fall_nx;

  // Stage p0/p1: synchronizer; stage p2: FSM state, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      state_p2 <= IDLE_LOW;
      cnt_p2   <= '0;
      level_p2 <= 1'b0;
      rise_p2  <= 1'b0;
      fall_p2  <= 1'b0;
    end else begin
      sync_p0  <= bus.btn_in;
      sync_p1  <= sync_p0;
      state_p2 <= state_nx;
      cnt_p2   <= cnt_nx;
      level_p2 <= level_nx;
      rise_p2  <= rise_nx;
      fall_p2  <= fall_nx;
    end
  end

  // A reversal while waiting drops back to the idle state of the current level,
  // so every candidate edge is qualified from a fresh count.
  always_comb begin
    state_nx = state_p2;
    cnt_nx   = cnt_p2;
    level_nx = level_p2;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state_p2)
      IDLE_LOW: begin
        if (sync_p1) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_p1) begin
          state_nx = IDLE_LOW;
          cnt_nx   = '0;
        end else if (cnt_p2 == CNT_LAST) begin
          state_nx = IDLE_HIGH;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_p2 + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_p1) begin
          state_nx = WAIT_LOW;
          cnt_nx   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_p1) begin
          state_nx = IDLE_HIGH;
          cnt_nx   = '0;
        end else if (cnt_p2 == CNT_LAST) begin
          state_nx = IDLE_LOW;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_p2 + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.btn_level  = level_p2;
  assign bus.rise_pulse = rise_p2;
  assign bus.fall_pulse = fall_p2;
  assign bus.busy       = (state_p2 == WAIT_HIGH) | (state_p2 == WAIT_LOW);

endmodule
